univ_shift_reg: RTL and testbench

Parametrised universal shift register and the successor to the fixed 8-bit parallel-load register.
- Adds run-time mode select: hold, load, shift left/right, rotate left/right, clear.
- Adds serial in/out on both ends.
- Adds a serial word-assembly counter that pulses when WIDTH shifts have completed.
- Used wherever the design needs SIPO, PISO or PIPO conversion from one block.

---
 rtl/univ_shift_reg.sv | 118 +++++++++++
 tb/tb_univ_shift_reg.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold/load/shift/rotate/clear with a serial word counter.
// Define UNIV_SHIFT_REG_PARITY_EN to add the registered even-parity output parity_out.
module univ_shift_reg #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     en,
   input  logic [2:0]               mode,
   input  logic                     serial_in_l,
   input  logic                     serial_in_r,
   input  logic [WIDTH-1:0]         parallel_in,
   output logic [WIDTH-1:0]         parallel_out,
   output logic                     serial_out_l,
   output logic                     serial_out_r,
   output logic [$clog2(WIDTH)-1:0] shift_cnt,
   output logic                     word_done
`ifdef UNIV_SHIFT_REG_PARITY_EN
   ,
   output logic                     parity_out
`endif
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [2:0] {
      M_HOLD  = 3'b000,
      M_LOAD  = 3'b001,
      M_SHL   = 3'b010,
      M_SHR   = 3'b011,
      M_ROL   = 3'b100,
      M_ROR   = 3'b101,
      M_CLEAR = 3'b110,
      M_RSVD  = 3'b111
   } mode_t;

   logic [WIDTH-1:0] r_reg;
   logic [CW-1:0]    r_cnt;
   logic             r_done;

   logic [WIDTH-1:0] w_nxt_reg;
   logic [CW-1:0]    w_nxt_cnt;
   logic             w_nxt_done;
   logic             w_shift;
   logic             w_wrap;

   assign w_wrap = (r_cnt == CW'(WIDTH - 1));

   always_comb begin
      w_nxt_reg  = r_reg;
      w_nxt_cnt  = r_cnt;
      w_nxt_done = 1'b0;
      w_shift    = 1'b0;
      if (en) begin
         case (mode_t'(mode))
            M_LOAD: begin
               w_nxt_reg = parallel_in;
               w_nxt_cnt = '0;
            end
            M_SHL: begin
               w_nxt_reg = {r_reg[WIDTH-2:0], serial_in_l};
               w_shift   = 1'b1;
            end
            M_SHR: begin
               w_nxt_reg = {serial_in_r, r_reg[WIDTH-1:1]};
               w_shift   = 1'b1;
            end
            M_ROL:   w_nxt_reg = {r_reg[WIDTH-2:0], r_reg[WIDTH-1]};
            M_ROR:   w_nxt_reg = {r_reg[0], r_reg[WIDTH-1:1]};
            M_CLEAR: begin
               w_nxt_reg = RST_VAL;
               w_nxt_cnt = '0;
            end
            default: w_nxt_reg = r_reg;
         endcase
      end
      // Counter tracks shift operations regardless of direction
      if (w_shift) begin
         if (w_wrap) begin
            w_nxt_cnt  = '0;
            w_nxt_done = 1'b1;
         end else begin
            w_nxt_cnt = r_cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_reg  <= RST_VAL;
         r_cnt  <= '0;
         r_done <= 1'b0;
      end else begin
         r_reg  <= w_nxt_reg;
         r_cnt  <= w_nxt_cnt;
         r_done <= w_nxt_done;
      end
   end

`ifdef UNIV_SHIFT_REG_PARITY_EN
   logic r_par;

   always_ff @(posedge clk) begin
      if (!rst_n) r_par <= ^RST_VAL;
      else        r_par <= ^w_nxt_reg;
   end

   assign parity_out = r_par;
`endif

   assign parallel_out = r_reg;
   assign serial_out_l = r_reg[WIDTH-1];
   assign serial_out_r = r_reg[0];
   assign shift_cnt    = r_cnt;
   assign word_done    = r_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg (WIDTH=8): directed scenarios plus random ops
// against an arithmetic reference model.
module tb_univ_shift_reg;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [2:0] mode;
   logic       serial_in_l;
   logic       serial_in_r;
   logic [7:0] parallel_in;
   logic [7:0] parallel_out;
   logic       serial_out_l;
   logic       serial_out_r;
   logic [2:0] shift_cnt;
   logic       word_done;
`ifdef UNIV_SHIFT_REG_PARITY_EN
   logic       parity_out;
`endif

   univ_shift_reg #(.WIDTH(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .mode         (mode),
      .serial_in_l  (serial_in_l),
      .serial_in_r  (serial_in_r),
      .parallel_in  (parallel_in),
      .parallel_out (parallel_out),
      .serial_out_l (serial_out_l),
      .serial_out_r (serial_out_r),
      .shift_cnt    (shift_cnt),
      .word_done    (word_done)
`ifdef UNIV_SHIFT_REG_PARITY_EN
      ,
      .parity_out   (parity_out)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   int m_reg = 0;
   int m_cnt = 0;
   int m_done = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input bit r, input bit e, input bit [2:0] md,
                       input bit sl, input bit sr, input bit [7:0] pin);
      bit shifted;
      rst_n       = r;
      en          = e;
      mode        = md;
      serial_in_l = sl;
      serial_in_r = sr;
      parallel_in = pin;
      @(posedge clk);
      shifted = 0;
      if (!r) begin
         m_reg = 0; m_cnt = 0; m_done = 0;
      end else if (!e) begin
         m_done = 0;
      end else begin
         m_done = 0;
         case (md)
            3'd1: begin m_reg = pin; m_cnt = 0; end
            3'd2: begin m_reg = (m_reg * 2 + sl) % 256; shifted = 1; end
            3'd3: begin m_reg = m_reg / 2 + sr * 128; shifted = 1; end
            3'd4: m_reg = (m_reg * 2) % 256 + m_reg / 128;
            3'd5: m_reg = m_reg / 2 + (m_reg % 2) * 128;
            3'd6: begin m_reg = 0; m_cnt = 0; end
            default: ;
         endcase
         if (shifted) begin
            m_cnt++;
            if (m_cnt == 8) begin m_cnt = 0; m_done = 1; end
         end
      end
      #1;
      chk("parallel_out", 32'(parallel_out), 32'(m_reg));
      chk("shift_cnt", 32'(shift_cnt), 32'(m_cnt));
      chk("word_done", 32'(word_done), 32'(m_done));
      chk("serial_out_l", 32'(serial_out_l), 32'(m_reg / 128));
      chk("serial_out_r", 32'(serial_out_r), 32'(m_reg % 2));
`ifdef UNIV_SHIFT_REG_PARITY_EN
      chk("parity_out", 32'(parity_out), 32'($countones(m_reg[7:0]) % 2));
`endif
   endtask

   initial begin
      bit [7:0] bits;
      bits = 8'b1011_0010;

      // reset
      step(0, 0, 0, 0, 0, 8'h00);
      step(0, 1, 2, 1, 1, 8'hFF);
      chk("rst_val", 32'(parallel_out), 32'h00);
      step(1, 1, 0, 0, 0, 8'h00);

      // load / hold
      step(1, 1, 1, 0, 0, 8'hAA);
      repeat (3) step(1, 1, 0, 1, 1, 8'h00);
      chk("hold_aa", 32'(parallel_out), 32'hAA);
      step(1, 1, 1, 0, 0, 8'hCC);
      chk("load_cc", 32'(parallel_out), 32'hCC);

      // SIPO
      step(1, 1, 6, 0, 0, 8'h00);
      for (int i = 7; i >= 0; i--) step(1, 1, 2, bits[i], 0, 8'h00);
      chk("sipo_b2", 32'(parallel_out), 32'hB2);
      chk("sipo_done", 32'(word_done), 32'd1);
      step(1, 1, 2, 0, 0, 8'h00);
      chk("sipo_9th_done", 32'(word_done), 32'd0);
      chk("sipo_9th_cnt", 32'(shift_cnt), 32'd1);

      // PISO / rotate
      step(1, 1, 1, 0, 0, 8'h81);
      chk("piso_sor0", 32'(serial_out_r), 32'd1);
      step(1, 1, 3, 0, 0, 8'h00);
      chk("shr_40", 32'(parallel_out), 32'h40);
      chk("piso_sor1", 32'(serial_out_r), 32'd0);
      step(1, 1, 1, 0, 0, 8'h81);
      step(1, 1, 4, 0, 0, 8'h00);
      chk("rol_03", 32'(parallel_out), 32'h03);
      step(1, 1, 1, 0, 0, 8'h81);
      step(1, 1, 5, 0, 0, 8'h00);
      chk("ror_c0", 32'(parallel_out), 32'hC0);
      chk("rot_cnt", 32'(shift_cnt), 32'd0);

      // enable / reserved
      step(1, 1, 1, 0, 0, 8'h5A);
      repeat (2) step(1, 0, 2, 1, 1, 8'h00);
      chk("en0_hold", 32'(parallel_out), 32'h5A);
      step(1, 1, 7, 1, 1, 8'hFF);
      chk("rsvd_hold", 32'(parallel_out), 32'h5A);

      // reset mid-word
      repeat (5) step(1, 1, 2, 1, 0, 8'h00);
      step(0, 1, 2, 1, 0, 8'h00);
      chk("midrst_cnt", 32'(shift_cnt), 32'd0);
      for (int i = 0; i < 8; i++) begin
         step(1, 1, 2, 1, 0, 8'h00);
         chk("midrst_done", 32'(word_done), 32'(i == 7));
      end

      // random
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 31) != 0), ($urandom_range(0, 7) != 0),
              3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
              8'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
